window_line_buffer: RTL and testbench

Streaming 3x3 neighbourhood generator for the cartoonifier pixel path, placed between the read buffer and the intensity/edge-detect/mean-average stages. It accepts one raster-order pixel per handshake, holds the previous two image lines in internal line memories, and emits a packed 3x3 window for every interior pixel centre. It is the parametrised successor to the fixed 9x24-bit pixelData bundle: it scales in pixel width and image size and adds valid/ready backpressure and frame resynchronisation.

---
 rtl/window_line_buffer_if.sv | 39 +++
 rtl/window_line_buffer.sv | 173 +++++++++++++++++
 tb/tb_window_line_buffer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_line_buffer_if.sv
// Pixel-in / window-out handshake bundle for window_line_buffer.
// out_row/out_col exist only when WLB_POSITION_EN is defined.
interface window_line_buffer_if #(
  parameter int PIXEL_W = 24,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic                 in_valid;
  logic                 in_sof;
  logic [PIXEL_W-1:0]   in_pixel;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [9*PIXEL_W-1:0] out_window;
  logic                 out_eof;
`ifdef WLB_POSITION_EN
  logic [RW-1:0]        out_row;
  logic [CW-1:0]        out_col;
`endif

  modport master (
    output in_valid, in_sof, in_pixel, out_ready,
    input  in_ready, out_valid, out_window, out_eof
`ifdef WLB_POSITION_EN
    , input out_row, out_col
`endif
  );

  modport slave (
    input  in_valid, in_sof, in_pixel, out_ready,
    output in_ready, out_valid, out_window, out_eof
`ifdef WLB_POSITION_EN
    , output out_row, out_col
`endif
  );
endinterface

// File: rtl/window_line_buffer.sv
// Streaming 3x3 window generator: two line memories, a 3-column shifter and a
// single-stage output register. Define WLB_POSITION_EN to add out_row/out_col.
module window_line_buffer #(
  parameter int PIXEL_W = 24,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480
) (
  input  logic                 clk,
  input  logic                 n_rst,
  window_line_buffer_if.slave  bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
  localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam int WW = 9 * PIXEL_W;

  logic [CW-1:0] col_q, col_d, pos_col_s;
  logic [RW-1:0] row_q, row_d, pos_row_s;
  logic          accept_s, load_s, last_s, in_ready_s;

  logic [PIXEL_W-1:0] l0_mem [IMG_W];
  logic [PIXEL_W-1:0] l1_mem [IMG_W];
  logic [PIXEL_W-1:0] l0_rd_s, l1_rd_s;

  // cols[c][r]: c=2 newest column, r=2 current line
  logic [2:0][2:0][PIXEL_W-1:0] cols_q, cols_d;
  logic [WW-1:0] win_s;

  logic          out_valid_q, out_valid_d;
  logic          out_eof_q, out_eof_d;
  logic [WW-1:0] out_window_q, out_window_d;
`ifdef WLB_POSITION_EN
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
`endif

  assign in_ready_s = !out_valid_q || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;

  // in_sof re-anchors the accepted pixel at (0,0) regardless of counter state
  always_comb begin
    if (bus.in_sof) begin
      pos_col_s = COL_ZERO;
      pos_row_s = ROW_ZERO;
    end else begin
      pos_col_s = col_q;
      pos_row_s = row_q;
    end
  end

  assign l0_rd_s = l0_mem[pos_col_s];
  assign l1_rd_s = l1_mem[pos_col_s];

  assign load_s = accept_s && (pos_row_s >= ROW_TWO) && (pos_col_s >= COL_TWO);
  assign last_s = (pos_row_s == ROW_LAST) && (pos_col_s == COL_LAST);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_s) begin
      if (pos_col_s == COL_LAST) begin
        col_d = COL_ZERO;
        if (pos_row_s == ROW_LAST) begin
          row_d = ROW_ZERO;
        end else begin
          row_d = pos_row_s + ROW_ONE;
        end
      end else begin
        col_d = pos_col_s + COL_ONE;
        row_d = pos_row_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  always_comb begin
    cols_d = cols_q;
    if (accept_s) begin
      cols_d[0] = cols_q[1];
      cols_d[1] = cols_q[2];
      cols_d[2] = {bus.in_pixel, l0_rd_s, l1_rd_s};
    end else begin
      cols_d = cols_q;
    end
  end

  // The loaded window is the post-shift column set, repacked as slot 3*r+c
  always_comb begin
    win_s = {WW{1'b0}};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_s[(3*r+c)*PIXEL_W +: PIXEL_W] = cols_d[c][r];
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_eof_d    = out_eof_q;
    out_window_d = out_window_q;
`ifdef WLB_POSITION_EN
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
`endif
    if (load_s) begin
      out_valid_d  = 1'b1;
      out_eof_d    = last_s;
      out_window_d = win_s;
`ifdef WLB_POSITION_EN
      out_row_d    = pos_row_s - ROW_ONE;
      out_col_d    = pos_col_s - COL_ONE;
`endif
    end else if (bus.out_ready) begin
      out_valid_d  = 1'b0;
      out_eof_d    = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
      out_eof_d    = out_eof_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_q        <= COL_ZERO;
      row_q        <= ROW_ZERO;
      cols_q       <= {(9*PIXEL_W){1'b0}};
      out_valid_q  <= 1'b0;
      out_eof_q    <= 1'b0;
      out_window_q <= {WW{1'b0}};
`ifdef WLB_POSITION_EN
      out_row_q    <= ROW_ZERO;
      out_col_q    <= COL_ZERO;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      cols_q       <= cols_d;
      out_valid_q  <= out_valid_d;
      out_eof_q    <= out_eof_d;
      out_window_q <= out_window_d;
`ifdef WLB_POSITION_EN
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
`endif
    end
  end

  // Line memories are not reset; row/column gating keeps stale lines out
  always_ff @(posedge clk) begin
    if (accept_s) begin
      l1_mem[pos_col_s] <= l0_rd_s;
      l0_mem[pos_col_s] <= bus.in_pixel;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_eof    = out_eof_q;
  assign bus.out_window = out_window_q;
`ifdef WLB_POSITION_EN
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
`endif
endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer on a 4x4, 8-bit frame: image-array model plus
// hand-computed window literals. Position ports are checked when WLB_POSITION_EN is set.
module tb_window_line_buffer;
  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  window_line_buffer_if #(.PIXEL_W(PW), .IMG_W(W), .IMG_H(H)) bus();
  window_line_buffer #(.PIXEL_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    logic        eof;
  } rx_t;

  int          checks = 0;
  int          passes = 0;
  logic [71:0] win_tab [4];
  rx_t         rx_q [$];
  logic [7:0]  img [H][W];
  logic        exp_valid, exp_eof;
  logic [71:0] exp_win;
  int          mrow, mcol, ready_drops;
  bit          track_ready = 1'b0;

  task automatic chkw(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // Window centred at (r-1, c-1) read straight out of the frame image
  function automatic logic [71:0] model_window(input int r, input int c);
    logic [71:0] w;
    w = 72'h0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*8 +: 8] = img[r-2+i][c-2+j];
    return w;
  endfunction

  initial begin : compare
    int r, c;
    exp_valid = 1'b0; exp_eof = 1'b0; exp_win = 72'h0; mrow = 0; mcol = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        exp_valid = 1'b0; exp_eof = 1'b0; exp_win = 72'h0; mrow = 0; mcol = 0;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
      end else begin
        chk1("out_valid", bus.out_valid, exp_valid);
        if (exp_valid) begin
          chkw("out_window", bus.out_window, exp_win);
          chk1("out_eof", bus.out_eof, exp_eof);
        end
        chk1("in_ready", bus.in_ready, !exp_valid || bus.out_ready);
        if (track_ready && !bus.in_ready) ready_drops++;
        if (bus.out_valid && bus.out_ready) rx_q.push_back('{bus.out_window, bus.out_eof});
        if (bus.in_valid && (!exp_valid || bus.out_ready)) begin
          r = bus.in_sof ? 0 : mrow;
          c = bus.in_sof ? 0 : mcol;
          img[r][c] = bus.in_pixel;
          if (r >= 2 && c >= 2) begin
            exp_valid = 1'b1;
            exp_win   = model_window(r, c);
            exp_eof   = (r == H-1) && (c == W-1);
          end else if (bus.out_ready) begin
            exp_valid = 1'b0;
            exp_eof   = 1'b0;
          end
          mcol = (c + 1) % W;
          mrow = (c == W-1) ? (r + 1) % H : r;
        end else if (bus.out_ready) begin
          exp_valid = 1'b0;
          exp_eof   = 1'b0;
        end
      end
    end
  end

  // Called and returns at posedge+1
  task automatic send_pixel(input logic [7:0] v, input logic sof);
    int   budget;
    logic acc;
    budget = 0;
    acc    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pixel = v;
    bus.in_sof   = sof;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    chk1("send_accept", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_rx(input string tag);
    chki({tag, "_count"}, rx_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      chkw({tag, "_win"}, rx_q[i].win, win_tab[i]);
      chk1({tag, "_eof"}, rx_q[i].eof, i == 3);
    end
  endtask

  task automatic reset_pulse(input string tag);
    #2 n_rst = 1'b0;
    #1;
    chk1({tag, "_valid"}, bus.out_valid, 1'b0);
    chk1({tag, "_eof"}, bus.out_eof, 1'b0);
    chkw({tag, "_window"}, bus.out_window, 72'h0);
    @(posedge clk);
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    win_tab[0] = 72'h0A0908060504020100;
    win_tab[1] = 72'h0B0A09070605030201;
    win_tab[2] = 72'h0E0D0C0A0908060504;
    win_tab[3] = 72'h0F0E0D0B0A09070605;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_pixel  = 8'h00;
    bus.out_ready = 1'b1;
    #12 n_rst = 1'b1;
    @(negedge clk);
    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chkw("reset_out_window", bus.out_window, 72'h0);
    chk1("reset_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Clean frame, continuous input and out_ready held high
    rx_q.delete();
    ready_drops = 0;
    track_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_pixel(8'(i), i == 0);
      if (i == 9) chk1("no_early_window", bus.out_valid, 1'b0);
      if (i == 10) begin
        chk1("first_valid", bus.out_valid, 1'b1);
        chkw("first_window", bus.out_window, win_tab[0]);
`ifdef WLB_POSITION_EN
        chki("first_row", int'(bus.out_row), 1);
        chki("first_col", int'(bus.out_col), 1);
`endif
      end
      if (i == 11) begin
        chk1("drain_load_valid", bus.out_valid, 1'b1);
        chkw("drain_load_window", bus.out_window, win_tab[1]);
      end
      if (i == 15) begin
        chkw("last_window", bus.out_window, win_tab[3]);
        chk1("last_eof", bus.out_eof, 1'b1);
`ifdef WLB_POSITION_EN
        chki("last_row", int'(bus.out_row), 2);
        chki("last_col", int'(bus.out_col), 2);
`endif
      end
    end
    idle(3);
    track_ready = 1'b0;
    chki("ready_drops", ready_drops, 0);
    check_rx("clean");
    chkw("model_pin_first", model_window(2, 2), win_tab[0]);
    chkw("model_pin_last", model_window(3, 3), win_tab[3]);

    // Backpressure for 5 cycles after the first window
    rx_q.delete();
    fork
      begin
        for (int i = 0; i < 16; i++) send_pixel(8'(i), i == 0);
      end
      begin : bp_watch
        logic [71:0] held;
        int          n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk1("bp_window_seen", bus.out_valid, 1'b1);
        bus.out_ready = 1'b0;
        held = bus.out_window;
        chkw("bp_held_first", held, win_tab[0]);
        repeat (5) begin
          @(negedge clk);
          chk1("bp_in_ready", bus.in_ready, 1'b0);
          chkw("bp_hold", bus.out_window, held);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    idle(3);
    check_rx("bp");

    // Six stray pixels, then a full frame re-anchored by in_sof
    rx_q.delete();
    for (int i = 0; i < 6; i++) send_pixel(8'(8'hE0 + i), 1'b0);
    for (int i = 0; i < 16; i++) send_pixel(8'(i), i == 0);
    idle(3);
    check_rx("resync");

    // Reset while the last window of a frame is pending
    for (int i = 0; i < 16; i++) send_pixel(8'(i), i == 0);
    chk1("pre_rst_valid", bus.out_valid, 1'b1);
    chk1("pre_rst_eof", bus.out_eof, 1'b1);
    reset_pulse("rst_eof");

    // Reset mid-frame with a stalled window, then a frame without in_sof
    bus.out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_pixel(8'(i), i == 0);
    chk1("pre_rst_mid_valid", bus.out_valid, 1'b1);
    reset_pulse("rst_mid");
    bus.out_ready = 1'b1;
    rx_q.delete();
    for (int i = 0; i < 16; i++) send_pixel(8'(i), 1'b0);
    idle(3);
    check_rx("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
